// File: rtl/slow_clock_period_meter_pkg.sv
// Shared types and constants for the slow clock period meter
// and the divided-clock chain it observes.
package slow_clock_period_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        LOST       = 2'd2
    } meas_state_t;

    localparam int unsigned SYS_CLK_HZ     = 50_000_000;
    localparam int unsigned DIV_1HZ_COUNT  = SYS_CLK_HZ / 2 - 1;
    localparam int unsigned DIV_10HZ_COUNT = SYS_CLK_HZ / 20 - 1;

    // Five seconds at 50 MHz: well beyond any divided blink clock period.
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 250_000_000;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser with rise/fall detection for slow
// asynchronous inputs (measured clocks, buttons).
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_in,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            s_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_prev;
    assign fall = ~s & s_prev;

endmodule

// File: rtl/slow_clock_period_meter.sv
// Measures period and high time of a slow input in clock_in cycles,
// flagging loss of signal when rising edges stop arriving.
module slow_clock_period_meter
    import slow_clock_period_meter_pkg::*;
#(
    parameter int          COUNT_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               meas_in,
    output logic [COUNT_W-1:0] period_out,
    output logic [COUNT_W-1:0] high_out,
    output logic               period_valid,
    output logic               signal_lost,
    output logic [1:0]         meas_state
);

    localparam logic [COUNT_W-1:0] TIMEOUT = COUNT_W'(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] ONE     = COUNT_W'(1);

    logic               meas_s_unused;
    logic               rise;
    logic               fall;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] high_lat;
    logic               timeout;
    meas_state_t        state;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock_in(clock_in),
        .reset   (reset),
        .d       (meas_in),
        .s       (meas_s_unused),
        .rise    (rise),
        .fall    (fall)
    );

    // Restarts at 1 on a rise so the value seen at the next edge is
    // the cycle distance back to the previous rise.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= ONE;
        end else if (cnt != TIMEOUT) begin
            cnt <= cnt + ONE;
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            high_lat <= '0;
        end else if (fall) begin
            high_lat <= cnt;
        end
    end

    assign timeout = (cnt == TIMEOUT) & ~rise;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state        <= WAIT_FIRST;
            period_out   <= '0;
            high_out     <= '0;
            period_valid <= 1'b0;
            signal_lost  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            signal_lost  <= (state == LOST);
            case (state)
                WAIT_FIRST: begin
                    if (rise) begin
                        state <= MEASURE;
                    end else if (timeout) begin
                        state <= LOST;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_out   <= cnt;
                        high_out     <= high_lat;
                        period_valid <= 1'b1;
                    end else if (timeout) begin
                        state <= LOST;
                    end
                end
                LOST: begin
                    // First edge back is only a new reference.
                    if (rise) begin
                        state <= MEASURE;
                    end
                end
                default: begin
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

    assign meas_state = state;

endmodule
